tblock_framer: RTL and testbench
================================

# tblock_framer

Parametrised successor of the transport-block shaper in the Tx path. It passes a byte/word stream to a block-oriented consumer, aligned to fixed-length transport blocks. When the upstream source stalls for too long, it closes the current block with fill words. It adds a configurable word width and fill pattern, block start/end markers, an optional keep-alive mode that emits whole fill blocks on an idle link, and a saturating padding statistic.

## Interface
- DATA_W, 8, data word width in bits.
- BLOCK_LEN, 480, words per transport block; must be at least 2.
- WAIT_CYCLES, 16, consecutive starved cycles before padding starts; must be at least 1.
- FILL_WORD, '0, DATA_W-bit value emitted during padding.
- KEEP_ALIVE, 0, if 1, a gap starting at a block boundary produces a full fill block.
- STAT_W, 32, width of the padding statistic.

Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ival  in  1  upstream word valid.
- idata  in  DATA_W  upstream word.
- ireq  in  1  downstream ready/request.
- oreq  out  1  ready to upstream.
- oval  out  1  word valid to downstream.
- odata  out  DATA_W  word to downstream.
- osop  out  1  current word is block word 0.
- oeop  out  1  current word is block word BLOCK_LEN-1.
- opad  out  1  current word is fill.
- opad_start  out  1  one-cycle pulse on the first cycle in PAD.
- stat_clr  in  1  clears pad_words.
- pad_words  out  STAT_W  count of fill words accepted downstream; saturates at all-ones.

## Operation
States:
- DATA: pass-through; oreq = ireq, oval = ival, odata = idata, opad = 0.
- PAD: oreq = 0, oval = 1, odata = FILL_WORD, opad = 1.

Counters and markers:
- A transfer happens when oval & ireq.
- blk_cnt counts transfers in both states and wraps BLOCK_LEN-1 to 0.
- osop = oval & (blk_cnt == 0); oeop = oval & (blk_cnt == BLOCK_LEN-1).

Gap timer (DATA only):
- ireq & ~ival increments gap_cnt.
- Any transfer clears gap_cnt.
- ~ireq holds gap_cnt.

DATA to PAD:
- Occurs on a starved cycle (ireq & ~ival) with gap_cnt == WAIT_CYCLES-1, provided blk_cnt != 0 or KEEP_ALIVE = 1.
- If blk_cnt == 0 and KEEP_ALIVE = 0, gap_cnt saturates at WAIT_CYCLES-1 and the block stays in DATA, with no output.
- gap_cnt is cleared on entry to PAD.

PAD to DATA:
- Occurs on the cycle after the transfer with blk_cnt == BLOCK_LEN-1.
- upstream ival arriving during PAD is ignored; it is not accepted because oreq = 0.

ireq low in PAD:
- oval stays 1 and odata stays FILL_WORD.
- No counter advances.

pad_words:
- Increments on every PAD transfer and saturates at all-ones.
- stat_clr has priority over the increment in the same cycle.

Reset:
- State goes to DATA; blk_cnt, gap_cnt and pad_words go to 0.
- opad and opad_start are 0.
- The remaining outputs follow the DATA-state equations: oreq = ireq, oval = ival, odata = idata, osop = ival.
- Reset mid-PAD abandons the partial block; no oeop is generated.

## Timing
- The data path is combinational: zero latency, with idata/ival to odata/oval and ireq to oreq in the same cycle.
- State, counters, opad_start and pad_words are registered.
- With continuous ireq, the first fill word appears WAIT_CYCLES+1 cycles after the last data transfer: WAIT_CYCLES starved cycles, then the state update.
- A padded block lasts exactly BLOCK_LEN - blk_cnt_at_entry transfers.
- Width rules:
  - blk_cnt is max(1, $clog2(BLOCK_LEN)) bits.
  - gap_cnt is max(1, $clog2(WAIT_CYCLES)) bits.
  - All comparisons use unsigned values sized to the counter width.

## Structure
- Package tblock_pkg:
  - state enum (ST_DATA, ST_PAD);
  - width helper function cnt_w(n) = max(1, $clog2(n)).
- Sub-module tblock_gap_timer:
  - Inputs: clr, tick, hold.
  - Outputs: expired and a saturating count.
  - Instantiated once for gap_cnt.
- The top level holds the FSM, blk_cnt, the output muxing and the statistic.

## Test plan
Unless a scenario states otherwise: DATA_W=8, BLOCK_LEN=8, WAIT_CYCLES=4, FILL_WORD=8'hA5, KEEP_ALIVE=0, ireq held 1.
- Continuous traffic:
  - Stimulus: 16 data words 0..15.
  - Response: 16 words out; osop on words 0 and 8; oeop on words 7 and 15; opad=0; pad_words=0.
- Padding after a stall:
  - Stimulus: 3 words, then ival=0.
  - Response: 4 cycles with oval=0; then opad_start pulses and 5 words of 8'hA5 with oreq=0 and oeop on the 5th; DATA is resumed; pad_words=5.
- Backpressure during PAD:
  - Stimulus: same as the previous scenario, with ireq=0 for 3 cycles after the 2nd fill word.
  - Response: odata holds 8'hA5 and oval holds 1; still exactly 5 fill words in total; oeop only on the last.
- Stall at a block boundary:
  - Stimulus: 8 words, then idle for 20 cycles.
  - Response with KEEP_ALIVE=0: no output.
  - Response with KEEP_ALIVE=1: after 4 starved cycles, a full 8-word fill block with osop on the 1st word and oeop on the 8th.
- Gap shorter than the timeout:
  - Stimulus: 3 words, 3 starved cycles, then data resumes.
  - Response: no fill; gap_cnt returns to 0; block alignment intact (oeop on the 8th data word).
- Reset and statistic clear:
  - Stimulus: rst asserted during the 3rd fill word.
  - Response: next cycle opad=0, pass-through, blk_cnt=0, pad_words=0.
  - Further stimulus: separately, stat_clr coincident with a fill transfer.
  - Response: pad_words=0.

Source files
------------

// File: rtl/tblock_pkg.sv
// Shared types and helpers for the transport-block framer.
package tblock_pkg;

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_PAD  = 1'b1
  } state_t;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tblock_gap_timer.sv
// Saturating starvation timer: counts ticks up to LIMIT-1 and flags expiry there.
module tblock_gap_timer #(
  parameter int LIMIT = 16,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         tick,
  input  logic         hold,
  output logic         expired,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  assign expired = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (!hold && tick && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/tblock_framer.sv
// Transport-block framer: zero-latency pass-through that closes starved blocks with
// fill words, marks block start/end, and keeps a saturating count of fill words sent.
module tblock_framer
  import tblock_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                BLOCK_LEN   = 480,
  parameter int                WAIT_CYCLES = 16,
  parameter logic [DATA_W-1:0] FILL_WORD   = '0,
  parameter int                KEEP_ALIVE  = 0,
  parameter int                STAT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ival,
  input  logic [DATA_W-1:0] idata,
  input  logic              ireq,
  output logic              oreq,
  output logic              oval,
  output logic [DATA_W-1:0] odata,
  output logic              osop,
  output logic              oeop,
  output logic              opad,
  output logic              opad_start,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] pad_words
);

  localparam int BW = cnt_w(BLOCK_LEN);
  localparam int GW = cnt_w(WAIT_CYCLES);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLOCK_LEN - 1);

  state_t          state;
  state_t          state_nxt;
  logic [BW-1:0]   blk_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            gap_exp;
  logic            in_pad;
  logic            xfer;
  logic            starved;
  logic            go_pad;
  logic            blk_first;
  logic            blk_last;

  // Reset forces the DATA view immediately, even before the state register clears.
  assign in_pad    = (state == ST_PAD) && !rst;
  assign blk_first = rst || (blk_cnt == '0);
  assign blk_last  = !rst && (blk_cnt == BLK_LAST);

  always_comb begin
    oreq  = ireq;
    oval  = ival;
    odata = idata;
    opad  = 1'b0;
    if (in_pad) begin
      oreq  = 1'b0;
      oval  = 1'b1;
      odata = FILL_WORD;
      opad  = 1'b1;
    end
  end

  assign osop    = oval && blk_first;
  assign oeop    = oval && blk_last;
  assign xfer    = oval && ireq;
  assign starved = !in_pad && ireq && !ival;
  // A stall on a block boundary only opens a fill block in keep-alive mode.
  assign go_pad  = starved && gap_exp && ((blk_cnt != '0) || (KEEP_ALIVE != 0));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_DATA: if (go_pad)              state_nxt = ST_PAD;
      ST_PAD:  if (xfer && blk_last)    state_nxt = ST_DATA;
      default:                          state_nxt = ST_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_DATA;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt <= '0;
    end else if (xfer) begin
      blk_cnt <= blk_last ? '0 : blk_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opad_start <= 1'b0;
    end else begin
      opad_start <= go_pad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      pad_words <= '0;
    end else if (in_pad && xfer && (pad_words != '1)) begin
      pad_words <= pad_words + 1'b1;
    end
  end

  tblock_gap_timer #(
    .LIMIT (WAIT_CYCLES),
    .W     (GW)
  ) u_gap (
    .clk     (clk),
    .rst     (rst),
    .clr     (xfer || go_pad || in_pad),
    .tick    (starved),
    .hold    (!ireq),
    .expired (gap_exp),
    .count   (gap_cnt)
  );

endmodule

// File: tb/tb_tblock_framer.sv
module tb_tblock_framer;

  typedef struct {
    int         sc;
    bit         chk;
    bit         sel;
    logic       rst, ival, ireq, clr;
    logic [7:0] idata;
    logic       oval, oreq, osop, oeop, opad, ops;
    logic [7:0] odata;
    int         pw;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ival = 1'b0;
  logic [7:0] idata = 8'h00;
  logic       ireq = 1'b1;
  logic       stat_clr = 1'b0;

  logic       oreq0, oval0, osop0, oeop0, opad0, ops0;
  logic [7:0] odata0;
  logic [31:0] pw0;
  logic       oreq1, oval1, osop1, oeop1, opad1, ops1;
  logic [7:0] odata1;
  logic [2:0] pw1;

  vec_t vt[$];
  vec_t sb[$];
  int   cur_sc  = 0;
  bit   cur_sel = 1'b0;
  int   errs    = 0;
  int   checks  = 0;

  always #5 clk = ~clk;

  tblock_framer #(
    .DATA_W(8), .BLOCK_LEN(8), .WAIT_CYCLES(4), .FILL_WORD(8'hA5),
    .KEEP_ALIVE(0), .STAT_W(32)
  ) dut0 (
    .clk(clk), .rst(rst), .ival(ival), .idata(idata), .ireq(ireq),
    .oreq(oreq0), .oval(oval0), .odata(odata0), .osop(osop0), .oeop(oeop0),
    .opad(opad0), .opad_start(ops0), .stat_clr(stat_clr), .pad_words(pw0)
  );

  tblock_framer #(
    .DATA_W(8), .BLOCK_LEN(8), .WAIT_CYCLES(4), .FILL_WORD(8'hA5),
    .KEEP_ALIVE(1), .STAT_W(3)
  ) dut1 (
    .clk(clk), .rst(rst), .ival(ival), .idata(idata), .ireq(ireq),
    .oreq(oreq1), .oval(oval1), .odata(odata1), .osop(osop1), .oeop(oeop1),
    .opad(opad1), .opad_start(ops1), .stat_clr(stat_clr), .pad_words(pw1)
  );

  function void rrow();
    vec_t v;
    v = '{sc: cur_sc, chk: 1'b0, sel: cur_sel, rst: 1'b1, ival: 1'b0, ireq: 1'b1,
          clr: 1'b0, idata: 8'h00, oval: 1'b0, oreq: 1'b1, osop: 1'b0, oeop: 1'b0,
          opad: 1'b0, ops: 1'b0, odata: 8'h00, pw: 0};
    vt.push_back(v);
  endfunction

  // DATA-state row: outputs mirror the inputs.
  function void drow(logic iv, logic [7:0] d, logic ir, logic sop, logic eop, int pw);
    vec_t v;
    v = '{sc: cur_sc, chk: 1'b1, sel: cur_sel, rst: 1'b0, ival: iv, ireq: ir,
          clr: 1'b0, idata: d, oval: iv, oreq: ir, osop: sop, oeop: eop,
          opad: 1'b0, ops: 1'b0, odata: d, pw: pw};
    vt.push_back(v);
  endfunction

  // PAD-state row: fill word, no upstream request, upstream ival ignored.
  function void prow(logic ir, logic sop, logic eop, logic st, int pw,
                     logic iv = 1'b0, logic clr = 1'b0);
    vec_t v;
    v = '{sc: cur_sc, chk: 1'b1, sel: cur_sel, rst: 1'b0, ival: iv, ireq: ir,
          clr: clr, idata: 8'h3C, oval: 1'b1, oreq: 1'b0, osop: sop, oeop: eop,
          opad: 1'b1, ops: st, odata: 8'hA5, pw: pw};
    vt.push_back(v);
  endfunction

  function void words(int n, int base, int first_blk);
    for (int i = 0; i < n; i++) begin
      drow(1'b1, 8'(base + i), 1'b1, ((first_blk + i) % 8) == 0,
           ((first_blk + i) % 8) == 7, 0);
    end
  endfunction

  function void idles(int n, int pw);
    for (int i = 0; i < n; i++) drow(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, pw);
  endfunction

  initial begin
    vec_t e;
    logic a_oval, a_oreq, a_osop, a_oeop, a_opad, a_ops;
    logic [7:0] a_odata;
    int a_pw;

    // 1: continuous traffic
    cur_sc = 1; cur_sel = 1'b0;
    rrow();
    for (int i = 0; i < 16; i++) drow(1'b1, 8'(i), 1'b1, (i % 8) == 0, (i % 8) == 7, 0);

    // 2: padding after a stall, with ignored upstream valid mid-pad
    cur_sc = 2;
    rrow(); words(3, 8'h10, 0); idles(4, 0);
    for (int k = 1; k <= 5; k++) prow(1'b1, 1'b0, k == 5, k == 1, k - 1, k == 3);
    drow(1'b1, 8'h40, 1'b1, 1'b1, 1'b0, 5);

    // 3: backpressure during PAD
    cur_sc = 3;
    rrow(); words(3, 8'h20, 0); idles(4, 0);
    prow(1'b1, 1'b0, 1'b0, 1'b1, 0);
    prow(1'b1, 1'b0, 1'b0, 1'b0, 1);
    for (int i = 0; i < 3; i++) prow(1'b0, 1'b0, 1'b0, 1'b0, 2);
    prow(1'b1, 1'b0, 1'b0, 1'b0, 2);
    prow(1'b1, 1'b0, 1'b0, 1'b0, 3);
    prow(1'b1, 1'b0, 1'b1, 1'b0, 4);
    drow(1'b1, 8'h50, 1'b1, 1'b1, 1'b0, 5);

    // 4: stall at a block boundary, no keep-alive
    cur_sc = 4;
    rrow(); words(8, 8'h30, 0); idles(20, 0);
    drow(1'b1, 8'h60, 1'b1, 1'b1, 1'b0, 0);

    // 5: stall at a block boundary, keep-alive; 3-bit statistic saturates at 7
    cur_sc = 5; cur_sel = 1'b1;
    rrow(); words(8, 8'h30, 0); idles(4, 0);
    for (int k = 1; k <= 8; k++) prow(1'b1, k == 1, k == 8, k == 1, k - 1);
    drow(1'b1, 8'h61, 1'b1, 1'b1, 1'b0, 7);

    // 6: gaps shorter than the timeout keep alignment
    cur_sc = 6; cur_sel = 1'b0;
    rrow(); words(3, 8'h70, 0); idles(3, 0); words(2, 8'h73, 3); idles(3, 0);
    words(3, 8'h75, 5);

    // 7: reset during the 3rd fill word
    cur_sc = 7;
    rrow(); words(3, 8'h80, 0); idles(4, 0);
    prow(1'b1, 1'b0, 1'b0, 1'b1, 0);
    prow(1'b1, 1'b0, 1'b0, 1'b0, 1);
    rrow();
    drow(1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 0);
    drow(1'b1, 8'h78, 1'b1, 1'b0, 1'b0, 0);

    // 8: stat_clr coincident with a fill transfer
    cur_sc = 8;
    rrow(); words(3, 8'h90, 0); idles(4, 0);
    prow(1'b1, 1'b0, 1'b0, 1'b1, 0);
    prow(1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1);
    prow(1'b1, 1'b0, 1'b0, 1'b0, 0);
    prow(1'b1, 1'b0, 1'b0, 1'b0, 1);
    prow(1'b1, 1'b0, 1'b1, 1'b0, 2);
    drow(1'b1, 8'h9A, 1'b1, 1'b1, 1'b0, 3);

    // 9: ireq low in DATA holds the gap timer
    cur_sc = 9;
    rrow(); words(3, 8'hB0, 0); idles(2, 0);
    for (int i = 0; i < 5; i++) drow(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    idles(2, 0);
    prow(1'b1, 1'b0, 1'b0, 1'b1, 0);

    foreach (vt[r]) begin
      @(posedge clk);
      #1;
      rst      = vt[r].rst;
      ival     = vt[r].ival;
      idata    = vt[r].idata;
      ireq     = vt[r].ireq;
      stat_clr = vt[r].clr;
      sb.push_back(vt[r]);
      @(negedge clk);
      e = sb.pop_front();
      if (e.sel) begin
        a_oval = oval1; a_oreq = oreq1; a_osop = osop1; a_oeop = oeop1;
        a_opad = opad1; a_ops = ops1; a_odata = odata1; a_pw = int'(pw1);
      end else begin
        a_oval = oval0; a_oreq = oreq0; a_osop = osop0; a_oeop = oeop0;
        a_opad = opad0; a_ops = ops0; a_odata = odata0; a_pw = int'(pw0);
      end
      if (e.chk) begin
        checks++;
        if (a_oval !== e.oval || a_oreq !== e.oreq || a_osop !== e.osop ||
            a_oeop !== e.oeop || a_opad !== e.opad || a_ops !== e.ops ||
            a_odata !== e.odata || a_pw != e.pw) begin
          errs++;
          $display("FAIL s%0d row%0d: got oval=%b oreq=%b odata=%h sop=%b eop=%b pad=%b pst=%b pw=%0d; want oval=%b oreq=%b odata=%h sop=%b eop=%b pad=%b pst=%b pw=%0d",
                   e.sc, r, a_oval, a_oreq, a_odata, a_osop, a_oeop, a_opad, a_ops, a_pw,
                   e.oval, e.oreq, e.odata, e.osop, e.oeop, e.opad, e.ops, e.pw);
        end
        if (a_ops === 1'b1) begin
          checks++;
          if (a_opad !== 1'b1 || a_odata !== 8'hA5 || a_oval !== 1'b1) begin
            errs++;
            $display("FAIL s%0d row%0d: expired wait did not enter PAD (pad=%b odata=%h oval=%b)",
                     e.sc, r, a_opad, a_odata, a_oval);
          end
        end
      end else if (e.rst) begin
        checks++;
        if (a_oval !== e.ival || a_oreq !== e.ireq || a_odata !== e.idata ||
            a_osop !== e.ival || a_opad !== 1'b0) begin
          errs++;
          $display("FAIL s%0d row%0d reset: got oval=%b oreq=%b odata=%h sop=%b pad=%b",
                   e.sc, r, a_oval, a_oreq, a_odata, a_osop, a_opad);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
